imm_decode_stage: RTL and testbench



---
 rtl/imm_pkg.sv | 39 +++
 rtl/imm_extract.sv | 96 +++++++++
 rtl/imm_decode_stage.sv | 128 ++++++++++++
 tb/tb_imm_decode_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared opcode constants, immediate-type enum and sign-extension helper
// for the immediate-decode stage.
package imm_pkg;

    // Base opcodes (instr[6:0]) recognised by the decoder.
    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcMiscMem = 7'b0001111;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcOpImm32 = 7'b0011011;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcOp32    = 7'b0111011;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcSystem  = 7'b1110011;

    typedef enum logic [2:0] {
        ImmNone = 3'd0,
        ImmI    = 3'd1,
        ImmS    = 3'd2,
        ImmB    = 3'd3,
        ImmU    = 3'd4,
        ImmJ    = 3'd5,
        ImmZ    = 3'd6
    } imm_type_e;

    // Sign-extend the low 'width' bits of value to 64 bits.
    function automatic logic [63:0] sext(input logic [63:0] value, input int unsigned width);
        logic signed [63:0] shifted;
        int unsigned        sh;
        sh       = 64 - width;
        shifted  = $signed(value << sh);
        return shifted >>> sh;
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: instruction word -> immediate,
// immediate type and illegal-encoding flag.
module imm_extract
    import imm_pkg::*;
#(
    parameter int unsigned XLEN         = 64,
    parameter bit          SUPPORT_ZIMM = 1'b1
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type,
    output logic            illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [63:0] imm_full;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Decode the format from the opcode and build the 64-bit immediate.
    always_comb begin
        imm_full = '0;
        imm_type = ImmNone;
        illegal  = 1'b0;
        case (opcode)
            OpcOpImm: begin
                imm_type = ImmI;
                imm_full = sext({52'b0, instr[31:20]}, 12);
                // RV32 shift amounts are 5 bits; shamt[5] set is malformed.
                if (XLEN == 32 && funct3[1:0] == 2'b01 && instr[25]) begin
                    illegal = 1'b1;
                end
            end
            OpcLoad, OpcJalr: begin
                imm_type = ImmI;
                imm_full = sext({52'b0, instr[31:20]}, 12);
            end
            OpcOpImm32: begin
                if (XLEN == 64) begin
                    imm_type = ImmI;
                    imm_full = sext({52'b0, instr[31:20]}, 12);
                end else begin
                    illegal = 1'b1;
                end
            end
            OpcStore: begin
                imm_type = ImmS;
                imm_full = sext({52'b0, instr[31:25], instr[11:7]}, 12);
            end
            OpcBranch: begin
                imm_type = ImmB;
                imm_full = sext({51'b0, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}, 13);
            end
            OpcLui, OpcAuipc: begin
                imm_type = ImmU;
                imm_full = sext({32'b0, instr[31:12], 12'b0}, 32);
            end
            OpcJal: begin
                imm_type = ImmJ;
                imm_full = sext({43'b0, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0},
                                21);
            end
            OpcSystem: begin
                if (funct3[2] && SUPPORT_ZIMM) begin
                    imm_type = ImmZ;
                    imm_full = {59'b0, instr[19:15]};
                end
            end
            OpcOp, OpcMiscMem: begin
                imm_type = ImmNone;
            end
            OpcOp32: begin
                if (XLEN != 64) begin
                    illegal = 1'b1;
                end
            end
            default: begin
                illegal = 1'b1;
            end
        endcase

        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end

        if (illegal) begin
            imm_full = '0;
            imm_type = ImmNone;
        end
    end

    assign imm = imm_full[XLEN-1:0];

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with a 2-entry skid buffer and
// PC-relative target computation.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int unsigned XLEN         = 64,
    parameter bit          SUPPORT_ZIMM = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output imm_type_e       out_imm_type,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    // Entry layout: {instr, pc, imm, type, target, illegal}
    localparam int unsigned EntryW = 32 + 3 * XLEN + 3 + 1;

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } skid_state_e;

    skid_state_e       state_q, state_d;
    logic [EntryW-1:0] main_q, main_d;
    logic [EntryW-1:0] skid_q, skid_d;
    logic [EntryW-1:0] new_entry;

    logic [XLEN-1:0]   dec_imm;
    imm_type_e         dec_type;
    logic              dec_illegal;
    logic              dec_pcrel;
    logic [XLEN-1:0]   dec_target;
    logic              accept;
    logic              pop;
    logic [2:0]        out_type_bits;

    imm_extract #(
        .XLEN         (XLEN),
        .SUPPORT_ZIMM (SUPPORT_ZIMM)
    ) u_imm_extract (
        .instr    (in_instr),
        .imm      (dec_imm),
        .imm_type (dec_type),
        .illegal  (dec_illegal)
    );

    // Target only for branches, JAL and AUIPC; wraps modulo 2^XLEN.
    always_comb begin
        dec_pcrel  = (dec_type == ImmB) || (dec_type == ImmJ) ||
                     (in_instr[6:0] == OpcAuipc && !dec_illegal);
        dec_target = dec_pcrel ? (in_pc + dec_imm) : '0;
    end

    assign new_entry = {in_instr, in_pc, dec_imm, dec_type, dec_target, dec_illegal};

    // Handshake signals come from registered state only.
    assign in_ready  = (state_q != StTwo);
    assign out_valid = (state_q != StEmpty);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Skid-buffer next state: main register feeds the outputs, skid holds overflow.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    main_d  = new_entry;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (accept && pop) begin
                    main_d = new_entry;
                end else if (accept) begin
                    skid_d  = new_entry;
                    state_d = StTwo;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = StOne;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
        // Flush drops everything held plus whatever is offered this cycle.
        if (flush) begin
            state_d = StEmpty;
        end
    end

    // State and entry registers; reset also clears the data outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign {out_instr, out_pc, out_imm, out_type_bits, out_target, out_illegal} = main_q;
    assign out_imm_type = imm_type_e'(out_type_bits);

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench: XLEN=64 (zimm on) and XLEN=32 (zimm off) instances
// share stimulus; a queue plus an arithmetic decode model gives expectations.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [31:0] out_instr64;
    logic [63:0] out_pc64, out_imm64, out_target64;
    logic [2:0]  out_type64;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_instr32;
    logic [31:0] out_pc32, out_imm32, out_target32;
    logic [2:0]  out_type32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(64), .SUPPORT_ZIMM(1'b1)) dut64 (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready64),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid64),
        .out_ready    (out_ready),
        .out_instr    (out_instr64),
        .out_pc       (out_pc64),
        .out_imm      (out_imm64),
        .out_imm_type (out_type64),
        .out_target   (out_target64),
        .out_illegal  (out_illegal64)
    );

    imm_decode_stage #(.XLEN(32), .SUPPORT_ZIMM(1'b0)) dut32 (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready32),
        .in_instr     (in_instr),
        .in_pc        (in_pc[31:0]),
        .out_valid    (out_valid32),
        .out_ready    (out_ready),
        .out_instr    (out_instr32),
        .out_pc       (out_pc32),
        .out_imm      (out_imm32),
        .out_imm_type (out_type32),
        .out_target   (out_target32),
        .out_illegal  (out_illegal32)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference decode, built from the format rules with signed arithmetic.
    // Types: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
    function automatic void ref_dec(input logic [31:0] ins, input logic [63:0] pc,
                                    input int xlen, input bit zimm,
                                    output logic [63:0] imm, output logic [2:0] ty,
                                    output logic [63:0] tgt, output bit ill);
        logic signed [11:0] v12;
        logic signed [12:0] v13;
        logic signed [19:0] v20;
        logic signed [20:0] v21;
        longint             v;
        bit                 pcrel;
        logic [63:0]        mask;
        v = 0; ty = 3'd0; ill = 1'b0; pcrel = 1'b0;
        case (ins[6:0])
            7'h13: begin
                ty = 3'd1; v12 = ins[31:20]; v = v12;
                if (xlen == 32 && ins[13:12] == 2'b01 && ins[25]) ill = 1'b1;
            end
            7'h03, 7'h67: begin ty = 3'd1; v12 = ins[31:20]; v = v12; end
            7'h1B: begin
                if (xlen == 64) begin ty = 3'd1; v12 = ins[31:20]; v = v12; end
                else ill = 1'b1;
            end
            7'h23: begin ty = 3'd2; v12 = {ins[31:25], ins[11:7]}; v = v12; end
            7'h63: begin
                ty = 3'd3; v13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                v = v13; pcrel = 1'b1;
            end
            7'h37, 7'h17: begin
                ty = 3'd4; v20 = ins[31:12]; v = v20; v = v * 4096;
                pcrel = (ins[6:0] == 7'h17);
            end
            7'h6F: begin
                ty = 3'd5; v21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                v = v21; pcrel = 1'b1;
            end
            7'h73: if (ins[14] && zimm) begin ty = 3'd6; v = ins[19:15]; end
            7'h33, 7'h0F: ;
            7'h3B: if (xlen != 64) ill = 1'b1;
            default: ill = 1'b1;
        endcase
        if (ill) begin v = 0; ty = 3'd0; pcrel = 1'b0; end
        mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : {64{1'b1}};
        imm  = v & mask;
        tgt  = pcrel ? ((pc + v) & mask) : 64'd0;
    endfunction

    // Scoreboard: {instr, pc} of accepted entries in order.
    logic [95:0] sbq[$];
    bit          rst_prev = 1'b0;
    logic [63:0] e_imm, e_tgt;
    logic [2:0]  e_ty;
    bit          e_ill;
    bit          m_acc, m_pop;

    always @(negedge clk) begin
        check_eq("out_valid64", {63'b0, out_valid64}, {63'b0, sbq.size() != 0});
        check_eq("in_ready64", {63'b0, in_ready64}, {63'b0, sbq.size() < 2});
        check_eq("out_valid32", {63'b0, out_valid32}, {63'b0, sbq.size() != 0});
        check_eq("in_ready32", {63'b0, in_ready32}, {63'b0, sbq.size() < 2});
        if (rst_prev) begin
            check_eq("rst_imm64", out_imm64, 64'd0);
            check_eq("rst_target64", out_target64, 64'd0);
            check_eq("rst_instr64", {32'b0, out_instr64}, 64'd0);
            check_eq("rst_pc32", {32'b0, out_pc32}, 64'd0);
        end
        if (sbq.size() != 0 && out_valid64 && out_valid32) begin
            ref_dec(sbq[0][95:64], sbq[0][63:0], 64, 1'b1, e_imm, e_ty, e_tgt, e_ill);
            check_eq("instr64", {32'b0, out_instr64}, {32'b0, sbq[0][95:64]});
            check_eq("pc64", out_pc64, sbq[0][63:0]);
            check_eq("imm64", out_imm64, e_imm);
            check_eq("type64", {61'b0, out_type64}, {61'b0, e_ty});
            check_eq("target64", out_target64, e_tgt);
            check_eq("illegal64", {63'b0, out_illegal64}, {63'b0, e_ill});
            ref_dec(sbq[0][95:64], {32'b0, sbq[0][31:0]}, 32, 1'b0, e_imm, e_ty, e_tgt, e_ill);
            check_eq("pc32", {32'b0, out_pc32}, {32'b0, sbq[0][31:0]});
            check_eq("imm32", {32'b0, out_imm32}, e_imm);
            check_eq("type32", {61'b0, out_type32}, {61'b0, e_ty});
            check_eq("target32", {32'b0, out_target32}, e_tgt);
            check_eq("illegal32", {63'b0, out_illegal32}, {63'b0, e_ill});
        end
        m_acc = in_valid && (sbq.size() < 2) && !flush && !rst;
        m_pop = (sbq.size() != 0) && out_ready;
        if (rst || flush) begin
            sbq.delete();
        end else begin
            if (m_pop) void'(sbq.pop_front());
            if (m_acc) sbq.push_back({in_instr, in_pc});
        end
        rst_prev = rst;
    end

    task automatic send_one(input logic [31:0] ins, input logic [63:0] pc);
        in_valid  = 1'b1;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
    endtask

    function automatic logic [31:0] gen_instr();
        logic [6:0]  opcs [16];
        logic [31:0] r;
        opcs = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17,
                 7'h6F, 7'h73, 7'h33, 7'h3B, 7'h0F, 7'h00, 7'h7F, 7'h12};
        r = $urandom;
        return {r[31:7], opcs[$urandom_range(0, 15)]};
    endfunction

    int          accepted;
    logic [31:0] first_instr;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_instr = 32'h0000_0013; in_pc = 64'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        check_eq("in_ready_after_rst", {63'b0, in_ready64}, 64'd1);
        check_eq("out_valid_after_rst", {63'b0, out_valid64}, 64'd0);

        send_one(32'hFE00_0EE3, 64'h1000);
        check_eq("beq_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFC);
        check_eq("beq_type", {61'b0, out_type64}, 64'd3);
        check_eq("beq_target64", out_target64, 64'hFFC);
        check_eq("beq_illegal", {63'b0, out_illegal64}, 64'd0);
        check_eq("beq_imm32", {32'b0, out_imm32}, 64'hFFFF_FFFC);

        send_one(32'h8000_02B7, 64'h40);
        check_eq("lui_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
        check_eq("lui_imm32", {32'b0, out_imm32}, 64'h8000_0000);
        check_eq("lui_type", {61'b0, out_type64}, 64'd4);
        check_eq("lui_target", out_target64, 64'd0);

        send_one(32'hFF9F_F06F, 64'h4);
        check_eq("jal_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFF8);
        check_eq("jal_target64", out_target64, 64'hFFFF_FFFF_FFFF_FFFC);
        check_eq("jal_target32", {32'b0, out_target32}, 64'hFFFF_FFFC);

        send_one(32'h300F_D073, 64'h8);
        check_eq("csrrwi_imm64", out_imm64, 64'd31);
        check_eq("csrrwi_type64", {61'b0, out_type64}, 64'd6);
        check_eq("csrrwi_type32_nozimm", {61'b0, out_type32}, 64'd0);
        check_eq("csrrwi_imm32_nozimm", {32'b0, out_imm32}, 64'd0);
        @(posedge clk); #1;

        // Backpressure: four offers against a stalled consumer.
        out_ready = 1'b0;
        accepted  = 0;
        first_instr = 32'h0000_0013;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_instr = {12'(i + 1), 13'h0, 7'h13};
            if (i == 0) first_instr = in_instr;
            if (in_ready64) accepted++;
            if (i >= 2) check_eq("bp_stable_instr", {32'b0, out_instr64}, {32'b0, first_instr});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_eq("bp_accepted", accepted, 64'd2);
        check_eq("bp_in_ready", {63'b0, in_ready64}, 64'd0);
        out_ready = 1'b1;
        check_eq("bp_drain0", {63'b0, out_valid64}, 64'd1);
        @(posedge clk); #1;
        check_eq("bp_drain1", {63'b0, out_valid64}, 64'd1);
        check_eq("bp_drain1_instr", {32'b0, out_instr64}, {32'b0, 12'd2, 13'h0, 7'h13});
        @(posedge clk); #1;
        check_eq("bp_drain2", {63'b0, out_valid64}, 64'd0);

        // Flush with both entries full, input in the flush cycle dropped.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0010_0093;
        @(posedge clk); #1;
        in_instr  = 32'h0020_0113;
        @(posedge clk); #1;
        check_eq("flush_full", {63'b0, in_ready64}, 64'd0);
        flush = 1'b1; in_instr = 32'h0030_0193; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_out_valid", {63'b0, out_valid64}, 64'd0);
        check_eq("flush_in_ready", {63'b0, in_ready64}, 64'd1);

        send_one(32'h0000_0000, 64'h100);
        check_eq("zero_illegal", {63'b0, out_illegal64}, 64'd1);
        check_eq("zero_imm", out_imm64, 64'd0);
        check_eq("zero_type", {61'b0, out_type64}, 64'd0);
        send_one(32'h0000_007F, 64'h104);
        check_eq("7f_illegal", {63'b0, out_illegal32}, 64'd1);
        check_eq("7f_imm", {32'b0, out_imm32}, 64'd0);
        check_eq("7f_type", {61'b0, out_type32}, 64'd0);
        @(posedge clk); #1;

        // Randomised traffic with occasional flush and reset.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            in_instr  = gen_instr();
            in_pc     = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, $urandom}
                                                    : {$urandom, $urandom};
            @(posedge clk); #1;
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
